// File: rtl/fft_stage_gen.sv
// One radix-2 DIT stage of an 8-point complex FFT: four butterflies per vector, optional /2 scaling, saturating outputs.
// Latency: 2 cycles (stage A registers x[i] and the twiddled x[j], stage B registers the saturated butterfly results).
// Backpressure: valid/ready; each stage advances only into a free or draining slot, output held stable while stalled.
// Ports: clk, rst (async active-low); in_r/in_i/in_valid/in_ready input vector; out_r/out_i/out_valid/out_ready
//        result vector; ovf/ovf_clr sticky saturation flag; frame_cnt counts output transfers (wraps).
module fft_stage_gen #(
    parameter int N     = 4,
    parameter int STAGE = 3,
    parameter int SCALE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [8*(2**N)-1:0] in_r,
    input  logic [8*(2**N)-1:0] in_i,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [8*(2**N)-1:0] out_r,
    output logic [8*(2**N)-1:0] out_i,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                ovf,
    input  logic                ovf_clr,
    output logic [15:0]         frame_cnt
);
    localparam int W  = 2**N;
    localparam int D  = 2**(STAGE-1);
    localparam int PW = 2*W + 2;
    // cos(pi/4) in Q(W-1); the real->longint cast rounds to nearest.
    localparam longint C_FULL = longint'(0.70710678 * (2.0 ** (W-1)));
    localparam logic signed [W:0] C = (W+1)'(C_FULL);

    if (STAGE < 1 || STAGE > 3) begin : g_bad_stage
        $error("fft_stage_gen: STAGE must be in 1..3");
    end

    logic signed [W-1:0] xa_r_d [4];
    logic signed [W-1:0] xa_i_d [4];
    logic signed [W:0]   t_r_d  [4];
    logic signed [W:0]   t_i_d  [4];
    logic signed [W-1:0] xa_r_q [4];
    logic signed [W-1:0] xa_i_q [4];
    logic signed [W:0]   t_r_q  [4];
    logic signed [W:0]   t_i_q  [4];
    logic signed [W-1:0] y_r_d  [8];
    logic signed [W-1:0] y_i_d  [8];
    logic [3:0]          sat_b;
    logic                va, vb, adv_a, adv_b;

    function automatic logic signed [W+1:0] scl(input logic signed [W+1:0] v);
        return (SCALE != 0) ? (v >>> 1) : v;
    endfunction

    // A W+2-bit value fits in W bits exactly when its top three bits agree.
    function automatic logic ovr(input logic signed [W+1:0] v);
        return !((v[W+1:W-1] == 3'b000) || (v[W+1:W-1] == 3'b111));
    endfunction

    function automatic logic signed [W-1:0] clip(input logic signed [W+1:0] v);
        if (ovr(v)) return v[W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return v[W-1:0];
    endfunction

    for (genvar b = 0; b < 4; b++) begin : g_bfly
        // b-th element with bit STAGE-1 clear, its partner and its twiddle exponent.
        localparam int I = ((b >> (STAGE-1)) << STAGE) | (b & (D-1));
        localparam int J = I + D;
        localparam int K = (I % D) * (4 / D);

        logic signed [W-1:0]  br, bi;
        logic signed [PW-1:0] pr, pi, p_sum, p_dif;
        logic signed [W:0]    tr, ti;
        logic signed [W+1:0]  s_r, s_i, d_r, d_i;
        logic signed [W+1:0]  ss_r, ss_i, sd_r, sd_i;

        assign xa_r_d[b] = in_r[W*I +: W];
        assign xa_i_d[b] = in_i[W*I +: W];
        assign br        = in_r[W*J +: W];
        assign bi        = in_i[W*J +: W];

        assign pr    = PW'(C) * PW'(br);
        assign pi    = PW'(C) * PW'(bi);
        assign p_sum = pr + pi;
        assign p_dif = pi - pr;

        // One floor shift on the full-precision sum, never per product.
        always_comb begin
            tr = {br[W-1], br};
            ti = {bi[W-1], bi};
            case (K)
                1: begin
                    tr = (W+1)'(p_sum >>> (W-1));
                    ti = (W+1)'(p_dif >>> (W-1));
                end
                2: begin
                    tr = {bi[W-1], bi};
                    ti = -{br[W-1], br};
                end
                3: begin
                    tr = (W+1)'(p_dif >>> (W-1));
                    ti = (W+1)'((-p_sum) >>> (W-1));
                end
                default: ;
            endcase
        end

        assign t_r_d[b] = tr;
        assign t_i_d[b] = ti;

        // Butterfly at W+2 bits so nothing wraps before scaling and saturation.
        assign s_r = (W+2)'(xa_r_q[b]) + (W+2)'(t_r_q[b]);
        assign s_i = (W+2)'(xa_i_q[b]) + (W+2)'(t_i_q[b]);
        assign d_r = (W+2)'(xa_r_q[b]) - (W+2)'(t_r_q[b]);
        assign d_i = (W+2)'(xa_i_q[b]) - (W+2)'(t_i_q[b]);

        assign ss_r = scl(s_r);
        assign ss_i = scl(s_i);
        assign sd_r = scl(d_r);
        assign sd_i = scl(d_i);

        assign y_r_d[I]  = clip(ss_r);
        assign y_i_d[I]  = clip(ss_i);
        assign y_r_d[J]  = clip(sd_r);
        assign y_i_d[J]  = clip(sd_i);
        assign sat_b[b]  = ovr(ss_r) | ovr(ss_i) | ovr(sd_r) | ovr(sd_i);
    end

    assign adv_b     = !vb || out_ready;
    assign adv_a     = !va || adv_b;
    assign in_ready  = rst && adv_a;
    assign out_valid = vb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            va <= 1'b0;
            for (int b = 0; b < 4; b++) begin
                xa_r_q[b] <= '0;
                xa_i_q[b] <= '0;
                t_r_q[b]  <= '0;
                t_i_q[b]  <= '0;
            end
        end else if (adv_a) begin
            va <= in_valid;
            if (in_valid) begin
                for (int b = 0; b < 4; b++) begin
                    xa_r_q[b] <= xa_r_d[b];
                    xa_i_q[b] <= xa_i_d[b];
                    t_r_q[b]  <= t_r_d[b];
                    t_i_q[b]  <= t_i_d[b];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vb        <= 1'b0;
            out_r     <= '0;
            out_i     <= '0;
            ovf       <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (adv_b) begin
                vb <= va;
                if (va) begin
                    for (int k = 0; k < 8; k++) begin
                        out_r[W*k +: W] <= y_r_d[k];
                        out_i[W*k +: W] <= y_i_d[k];
                    end
                end
            end
            // A saturating load outranks a simultaneous clear.
            if (adv_b && va && (|sat_b)) ovf <= 1'b1;
            else if (ovf_clr)            ovf <= 1'b0;
            if (vb && out_ready) frame_cnt <= frame_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_fft_stage_gen.sv
module tb_fft_stage_gen;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_r, in_i;
    logic         in_valid, out_ready, ovf_clr;
    logic [127:0] o_r [4];
    logic [127:0] o_i [4];
    logic         o_v [4];
    logic         irdy [4];
    logic         ovf [4];
    logic [15:0]  fc [4];

    int st [4] = '{3, 3, 1, 2};
    int sc [4] = '{0, 1, 0, 0};

    int           n_assert = 0;
    int           n_fail   = 0;
    int           n_acc    = 0;
    int           n_xfer   = 0;
    int           fc_model = 0;
    bit           sat_seen [4];
    logic [127:0] q_r [$];
    logic [127:0] q_i [$];

    always #5 clk = ~clk;

    fft_stage_gen #(.N(4), .STAGE(3), .SCALE(0)) u_s3 (
        .clk(clk), .rst(rst), .in_r(in_r), .in_i(in_i), .in_valid(in_valid), .in_ready(irdy[0]),
        .out_r(o_r[0]), .out_i(o_i[0]), .out_valid(o_v[0]), .out_ready(out_ready),
        .ovf(ovf[0]), .ovf_clr(ovf_clr), .frame_cnt(fc[0]));
    fft_stage_gen #(.N(4), .STAGE(3), .SCALE(1)) u_s3s (
        .clk(clk), .rst(rst), .in_r(in_r), .in_i(in_i), .in_valid(in_valid), .in_ready(irdy[1]),
        .out_r(o_r[1]), .out_i(o_i[1]), .out_valid(o_v[1]), .out_ready(out_ready),
        .ovf(ovf[1]), .ovf_clr(ovf_clr), .frame_cnt(fc[1]));
    fft_stage_gen #(.N(4), .STAGE(1), .SCALE(0)) u_s1 (
        .clk(clk), .rst(rst), .in_r(in_r), .in_i(in_i), .in_valid(in_valid), .in_ready(irdy[2]),
        .out_r(o_r[2]), .out_i(o_i[2]), .out_valid(o_v[2]), .out_ready(out_ready),
        .ovf(ovf[2]), .ovf_clr(ovf_clr), .frame_cnt(fc[2]));
    fft_stage_gen #(.N(4), .STAGE(2), .SCALE(0)) u_s2 (
        .clk(clk), .rst(rst), .in_r(in_r), .in_i(in_i), .in_valid(in_valid), .in_ready(irdy[3]),
        .out_r(o_r[3]), .out_i(o_i[3]), .out_valid(o_v[3]), .out_ready(out_ready),
        .ovf(ovf[3]), .ovf_clr(ovf_clr), .frame_cnt(fc[3]));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] el(input logic [127:0] v, input int k);
        return v[16*k +: 16];
    endfunction

    function automatic longint fdiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    // Reference: the stage written directly from the butterfly equations with 64-bit integers.
    function automatic void model(input int stage, input int scale, input logic [127:0] xr,
                                  input logic [127:0] xi, output logic [127:0] yr,
                                  output logic [127:0] yi, output bit sat);
        longint ar [8];
        longint ai [8];
        longint rr [8];
        longint ri [8];
        longint c, tr, ti, v;
        int     d, j, e;
        c   = 23170;
        d   = 1 << (stage - 1);
        sat = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ar[k] = longint'($signed(xr[16*k +: 16]));
            ai[k] = longint'($signed(xi[16*k +: 16]));
        end
        for (int i = 0; i < 8; i++) begin
            if (((i >> (stage - 1)) & 1) == 0) begin
                j = i + d;
                e = (i % d) * (4 / d);
                tr = ar[j];
                ti = ai[j];
                if (e == 1) begin
                    tr = fdiv(c * ar[j] + c * ai[j], 32768);
                    ti = fdiv(c * ai[j] - c * ar[j], 32768);
                end else if (e == 2) begin
                    tr = ai[j];
                    ti = -ar[j];
                end else if (e == 3) begin
                    tr = fdiv(c * ai[j] - c * ar[j], 32768);
                    ti = fdiv(-(c * ar[j] + c * ai[j]), 32768);
                end
                rr[i] = ar[i] + tr;
                ri[i] = ai[i] + ti;
                rr[j] = ar[i] - tr;
                ri[j] = ai[i] - ti;
            end
        end
        for (int k = 0; k < 8; k++) begin
            for (int p = 0; p < 2; p++) begin
                v = (p == 0) ? rr[k] : ri[k];
                if (scale != 0) v = fdiv(v, 2);
                if (v > 32767) begin
                    v = 32767;
                    sat = 1'b1;
                end else if (v < -32768) begin
                    v = -32768;
                    sat = 1'b1;
                end
                if (p == 0) yr[16*k +: 16] = 16'(v);
                else        yi[16*k +: 16] = 16'(v);
            end
        end
    endfunction

    function automatic logic [127:0] rvec();
        logic [127:0] v;
        int s;
        for (int k = 0; k < 8; k++) begin
            s = $urandom_range(0, 7);
            v[16*k +: 16] = (s == 0) ? 16'h8000 : (s == 1) ? 16'h7FFF : 16'($urandom);
        end
        return v;
    endfunction

    // One clock: sample handshakes at the falling edge, score any output transfer, then step past the rising edge.
    task automatic tick();
        logic [127:0] er, ei;
        bit           s;
        @(negedge clk);
        if (in_valid && irdy[0]) begin
            q_r.push_back(in_r);
            q_i.push_back(in_i);
            n_acc++;
        end
        if (o_v[0] && out_ready) begin
            n_xfer++;
            fc_model = (fc_model + 1) & 16'hFFFF;
            chk("sb_nonempty", 128'(q_r.size() != 0), 128'd1);
            if (q_r.size() != 0) begin
                for (int d = 0; d < 4; d++) begin
                    model(st[d], sc[d], q_r[0], q_i[0], er, ei, s);
                    chk($sformatf("sb_out_r[%0d]", d), o_r[d], er);
                    chk($sformatf("sb_out_i[%0d]", d), o_i[d], ei);
                    if (s) sat_seen[d] = 1'b1;
                end
                void'(q_r.pop_front());
                void'(q_i.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic [127:0] vr, input logic [127:0] vi);
        in_r = vr;
        in_i = vi;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_not_early", o_v[0], 1'b0);
        tick();
        chk("lat_valid", o_v[0], 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] vr, vi, er, ei;
        logic [127:0] vs_r [3];
        logic [127:0] vs_i [3];
        bit           s;
        int           sent, a0, x0, budget;

        rst = 1'b0; in_r = '0; in_i = '0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("rst_out_valid[%0d]", d), o_v[d], 1'b0);
            chk($sformatf("rst_in_ready[%0d]", d), irdy[d], 1'b0);
            chk($sformatf("rst_ovf[%0d]", d), ovf[d], 1'b0);
            chk($sformatf("rst_frame_cnt[%0d]", d), fc[d], 16'd0);
            chk($sformatf("rst_out_r[%0d]", d), o_r[d], 128'd0);
        end
        rst = 1'b1;
        #1;
        chk("in_ready_after_release", irdy[0], 1'b1);

        // Two equal inputs in one butterfly with W0.
        vr = '0; vi = '0;
        vr[16*0 +: 16] = 16'd1000;
        vr[16*4 +: 16] = 16'd1000;
        send1(vr, vi);
        chk("dc_y0_r", el(o_r[0], 0), 16'd2000);
        chk("dc_y0_i", el(o_i[0], 0), 16'd0);
        chk("dc_y4_r", el(o_r[0], 4), 16'd0);
        chk("dc_y4_i", el(o_i[0], 4), 16'd0);
        chk("dc_ovf", ovf[0], 1'b0);
        tick();

        // W2 and W1 twiddles.
        vr = '0; vi = '0;
        vr[16*6 +: 16] = 16'd1000;
        vr[16*5 +: 16] = 16'd16384;
        send1(vr, vi);
        chk("w2_y2_r", el(o_r[0], 2), 16'd0);
        chk("w2_y2_i", el(o_i[0], 2), 16'hFC18);
        chk("w2_y6_r", el(o_r[0], 6), 16'd0);
        chk("w2_y6_i", el(o_i[0], 6), 16'd1000);
        chk("w1_y1_r", el(o_r[0], 1), 16'h2D41);
        chk("w1_y1_i", el(o_i[0], 1), 16'hD2BF);
        chk("w1_y5_r", el(o_r[0], 5), 16'hD2BF);
        chk("w1_y5_i", el(o_i[0], 5), 16'h2D41);
        tick();

        // Saturation, scaling, sticky flag and its clear.
        vr = '0; vi = '0;
        vr[16*0 +: 16] = 16'd30000;
        vr[16*4 +: 16] = 16'd30000;
        send1(vr, vi);
        chk("sat_y0_r", el(o_r[0], 0), 16'h7FFF);
        chk("sat_y0_i", el(o_i[0], 0), 16'd0);
        chk("sat_y4_r", el(o_r[0], 4), 16'd0);
        chk("sat_ovf", ovf[0], 1'b1);
        chk("scl_y0_r", el(o_r[1], 0), 16'd30000);
        chk("scl_ovf", ovf[1], 1'b0);
        tick();
        tick();
        chk("ovf_sticky", ovf[0], 1'b1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", ovf[0], 1'b0);
        for (int d = 0; d < 4; d++) sat_seen[d] = 1'b0;

        // Reset with two vectors in flight.
        out_ready = 1'b0;
        in_r = rvec(); in_i = rvec(); in_valid = 1'b1;
        tick();
        in_r = rvec(); in_i = rvec();
        tick();
        in_valid = 1'b0;
        chk("mid_inflight", o_v[0], 1'b1);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("mid_out_valid[%0d]", d), o_v[d], 1'b0);
            chk($sformatf("mid_out_r[%0d]", d), o_r[d], 128'd0);
            chk($sformatf("mid_frame_cnt[%0d]", d), fc[d], 16'd0);
            chk($sformatf("mid_in_ready[%0d]", d), irdy[d], 1'b0);
        end
        q_r.delete(); q_i.delete();
        fc_model = 0;
        for (int d = 0; d < 4; d++) sat_seen[d] = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        #1;
        chk("mid_in_ready_release", irdy[0], 1'b1);
        out_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("mid_no_stale", o_v[0], 1'b0);
        end

        // Stall: V1, V2 accepted, V3 held until the output drains.
        for (int k = 0; k < 3; k++) begin
            vs_r[k] = rvec();
            vs_i[k] = rvec();
        end
        out_ready = 1'b0;
        sent = 0;
        x0 = n_xfer;
        in_r = vs_r[0]; in_i = vs_i[0]; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            a0 = n_acc;
            tick();
            if (n_acc != a0) sent++;
            if (sent < 3) begin
                in_r = vs_r[sent];
                in_i = vs_i[sent];
            end else begin
                in_valid = 1'b0;
            end
        end
        chk("stall_accepted", 128'(sent), 128'd2);
        chk("stall_in_ready", irdy[0], 1'b0);
        chk("stall_out_valid", o_v[0], 1'b1);
        model(3, 0, vs_r[0], vs_i[0], er, ei, s);
        chk("stall_hold_r", o_r[0], er);
        chk("stall_hold_i", o_i[0], ei);
        out_ready = 1'b1;
        budget = 0;
        while ((n_xfer - x0 < 3) && (budget < 20)) begin
            a0 = n_acc;
            tick();
            if (n_acc != a0) sent++;
            if (sent < 3) begin
                in_r = vs_r[sent];
                in_i = vs_i[sent];
            end else begin
                in_valid = 1'b0;
            end
            budget++;
        end
        chk("stall_emitted", 128'(n_xfer - x0), 128'd3);
        chk("stall_frame_cnt", fc[0], 16'd3);

        // Throughput with both sides always ready.
        in_valid = 1'b0;
        repeat (3) tick();
        a0 = n_acc;
        x0 = n_xfer;
        for (int c = 0; c < 40; c++) begin
            in_r = rvec(); in_i = rvec(); in_valid = 1'b1;
            chk("tput_in_ready", irdy[0], 1'b1);
            tick();
        end
        chk("tput_accepts", 128'(n_acc - a0), 128'd40);
        chk("tput_transfers", 128'(n_xfer - x0), 128'd38);

        // Random traffic with random backpressure.
        for (int c = 0; c < 600; c++) begin
            in_r = rvec();
            in_i = rvec();
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("drain_empty", 128'(q_r.size()), 128'd0);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("end_frame_cnt[%0d]", d), fc[d], 16'(fc_model));
            chk($sformatf("end_ovf[%0d]", d), ovf[d], sat_seen[d]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
